// File: rtl/tt_harness_pkg.sv
// Shared state type and width helpers for the TinyTapeout vector harness.
package tt_harness_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // One counter serves both the reset hold and the per-vector settle window
    function automatic int unsigned cnt_w(
        input int unsigned rst_cycles,
        input int unsigned settle
    );
        int unsigned m;
        m = (rst_cycles > settle + 1) ? rst_cycles : settle + 1;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tt_vec_mem.sv
// Vector table: one synchronous write port, one combinational read port.
module tt_vec_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int EW    = 48
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [EW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [EW-1:0] o_rdata
);

    logic [EW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tt_vector_harness.sv
// Plays a stored vector table into a TinyTapeout project and checks
// the masked pad outputs, counting mismatches and the first failing index.
module tt_vector_harness
    import tt_harness_pkg::*;
#(
    parameter int DW         = 8,
    parameter int DEPTH      = 16,
    parameter int SETTLE     = 2,
    parameter int RST_CYCLES = 2,
    parameter int ERR_W      = 8,
    localparam int AW        = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [2*DW-1:0]  cfg_stim,
    input  logic [2*DW-1:0]  cfg_exp,
    input  logic [2*DW-1:0]  cfg_mask,
    input  logic [AW:0]      vec_count,
    input  logic             start,
    input  logic             abort,
    output logic             dut_rst_n,
    output logic             dut_ena,
    output logic [DW-1:0]    dut_ui_in,
    output logic [DW-1:0]    dut_uio_in,
    input  logic [DW-1:0]    dut_uo_out,
    input  logic [DW-1:0]    dut_uio_out,
    input  logic [DW-1:0]    dut_uio_oe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    first_fail,
    output logic             fail_valid
);

    localparam int BW = 2 * DW;
    localparam int CW = cnt_w(RST_CYCLES, SETTLE);
    localparam logic [AW:0]      DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0]      ONE_N   = (AW+1)'(1);
    localparam logic [AW-1:0]    ONE_A   = AW'(1);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [ERR_W-1:0] ONE_E   = ERR_W'(1);
    localparam logic [CW-1:0]    RST_LD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    SET_LD  = CW'(SETTLE);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_nvec;
    logic [ERR_W-1:0] r_err;
    logic [AW-1:0]    r_ff;
    logic             r_fv;

    logic [3*BW-1:0]  w_entry;
    logic [BW-1:0]    w_stim;
    logic [BW-1:0]    w_exp;
    logic [BW-1:0]    w_mask;
    logic [BW-1:0]    w_act;
    logic [BW-1:0]    w_cmp;
    logic             w_mismatch;
    logic             w_cnt_zero;
    logic             w_last;
    logic             w_go;

    tt_vec_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .EW    (3*BW)
    ) u_mem (
        .clk     (clk),
        .i_we    (cfg_we && !busy),
        .i_waddr (cfg_addr),
        .i_wdata ({cfg_mask, cfg_exp, cfg_stim}),
        .i_raddr (r_idx),
        .o_rdata (w_entry)
    );

    assign {w_mask, w_exp, w_stim} = w_entry;

    // uio bits only count when the project is actually driving them
    assign w_act      = {dut_uio_out & dut_uio_oe, dut_uo_out};
    assign w_cmp      = w_mask & {dut_uio_oe, {DW{1'b1}}};
    assign w_mismatch = |((w_act ^ w_exp) & w_cmp);

    assign w_cnt_zero = (r_cnt == '0);
    assign w_last     = ({1'b0, r_idx} == r_nvec - ONE_N);
    assign w_go       = start && !abort && !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE, DONE: if (start) w_next = RESET;
                RESET: begin
                    if (w_cnt_zero) begin
                        w_next = (r_nvec == '0) ? DONE : RUN;
                    end
                end
                RUN: if (w_cnt_zero && w_last) w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        dut_rst_n  = 1'b0;
        dut_ena    = 1'b0;
        dut_ui_in  = '0;
        dut_uio_in = '0;
        unique case (r_state)
            RESET: begin
                busy    = 1'b1;
                dut_ena = 1'b1;
            end
            RUN: begin
                busy      = 1'b1;
                dut_rst_n = 1'b1;
                dut_ena   = 1'b1;
                {dut_uio_in, dut_ui_in} = w_stim;
            end
            DONE: begin
                done      = 1'b1;
                dut_rst_n = 1'b1;
                dut_ena   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_nvec <= '0;
            r_err  <= '0;
            r_ff   <= '0;
            r_fv   <= 1'b0;
        end else if (w_go) begin
            r_cnt  <= RST_LD;
            r_idx  <= '0;
            r_nvec <= (vec_count > DEPTH_V) ? DEPTH_V : vec_count;
            r_err  <= '0;
            r_fv   <= 1'b0;
        end else if (!abort) begin
            if (r_state == RESET) begin
                r_cnt <= w_cnt_zero ? SET_LD : r_cnt - ONE_C;
            end else if (r_state == RUN) begin
                if (w_cnt_zero) begin
                    r_cnt <= SET_LD;
                    r_idx <= r_idx + ONE_A;
                    if (w_mismatch) begin
                        if (r_err != '1) r_err <= r_err + ONE_E;
                        if (!r_fv) begin
                            r_ff <= r_idx;
                            r_fv <= 1'b1;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt - ONE_C;
                end
            end
        end
    end

    assign pass       = done && (r_err == '0);
    assign err_count  = r_err;
    assign first_fail = r_ff;
    assign fail_valid = r_fv;

endmodule
